// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a word-addressed, registered-read data memory.
// Handles byte/halfword extraction on loads and read-modify-write for SB/SH.
module load_store_unit #(
   parameter int MEM_WORDS = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] mem_A,
   output logic [31:0] mem_WD,
   output logic        mem_WE,
   input  logic [31:0] mem_RD
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      MERGE  = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t      state;
   logic        we_r;
   logic [2:0]  funct3_r;
   logic [31:0] addr_r;
   logic [31:0] wdata_r;
   logic        err_r;
   logic [31:0] wd_r;

   function automatic logic req_error(input logic we, input logic [2:0] f3, input logic [31:0] addr);
      logic illegal;
      logic misaligned;
      logic out_of_range;
      illegal      = we ? (f3 >= 3'd3) : ((f3 == 3'd3) || (f3 >= 3'd6));
      misaligned   = ((f3[1:0] == 2'd1) && addr[0]) ||
                     ((f3[1:0] == 2'd2) && (addr[1:0] != 2'b00));
      out_of_range = ({2'b00, addr[31:2]} >= 32'(MEM_WORDS));
      return illegal | misaligned | out_of_range;
   endfunction

   function automatic logic [31:0] load_extend(input logic [31:0] rd, input logic [2:0] f3,
                                               input logic [1:0] lane);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      case (lane)
         2'd0:    b = rd[7:0];
         2'd1:    b = rd[15:8];
         2'd2:    b = rd[23:16];
         2'd3:    b = rd[31:24];
         default: b = 8'd0;
      endcase
      h = lane[1] ? rd[31:16] : rd[15:0];
      case (f3)
         3'd0:    res = {{24{b[7]}}, b};
         3'd4:    res = {24'd0, b};
         3'd1:    res = {{16{h[15]}}, h};
         3'd5:    res = {16'd0, h};
         3'd2:    res = rd;
         default: res = 32'd0;
      endcase
      return res;
   endfunction

   function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [2:0] f3, input logic [1:0] lane);
      logic [31:0] res;
      res = old;
      if (f3 == 3'd0) begin
         case (lane)
            2'd0:    res[7:0]   = wd[7:0];
            2'd1:    res[15:8]  = wd[7:0];
            2'd2:    res[23:16] = wd[7:0];
            2'd3:    res[31:24] = wd[7:0];
            default: res = old;
         endcase
      end else if (lane[1]) begin
         res[31:16] = wd[15:0];
      end else begin
         res[15:0] = wd[15:0];
      end
      return res;
   endfunction

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign rsp_err   = (state == RESP) && err_r;
   assign rsp_rdata = ((state == RESP) && !we_r && !err_r) ?
                      load_extend(mem_RD, funct3_r, addr_r[1:0]) : 32'd0;
   // In MERGE the old word only arrives this cycle, so the merged write data is formed from mem_RD directly.
   assign mem_WD    = (state == MERGE) ? store_merge(mem_RD, wdata_r, funct3_r, addr_r[1:0]) : wd_r;

   // Request FSM with registered memory address, write enable and full-word write data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         we_r     <= 1'b0;
         funct3_r <= 3'd0;
         addr_r   <= 32'd0;
         wdata_r  <= 32'd0;
         err_r    <= 1'b0;
         wd_r     <= 32'd0;
         mem_A    <= 32'd0;
         mem_WE   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  we_r     <= req_we;
                  funct3_r <= req_funct3;
                  addr_r   <= req_addr;
                  wdata_r  <= req_wdata;
                  if (req_error(req_we, req_funct3, req_addr)) begin
                     err_r <= 1'b1;
                     state <= RESP;
                  end else begin
                     err_r  <= 1'b0;
                     state  <= ACCESS;
                     mem_A  <= {2'b00, req_addr[31:2]};
                     mem_WE <= req_we && (req_funct3 == 3'd2);
                     wd_r   <= (req_we && (req_funct3 == 3'd2)) ? req_wdata : 32'd0;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            ACCESS: begin
               wd_r <= 32'd0;
               if (we_r && (funct3_r != 3'd2)) begin
                  state  <= MERGE;
                  mem_WE <= 1'b1;
               end else begin
                  state  <= RESP;
                  mem_WE <= 1'b0;
                  mem_A  <= 32'd0;
               end
            end
            MERGE: begin
               state  <= RESP;
               mem_WE <= 1'b0;
               mem_A  <= 32'd0;
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state  <= IDLE;
               mem_WE <= 1'b0;
               mem_A  <= 32'd0;
               wd_r   <= 32'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: registered memory model, directed cases
// from the behaviour description, reset during RMW, held-valid traffic and random traffic.
module tb_load_store_unit;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] mem_A;
   logic [31:0] mem_WD;
   logic        mem_WE;
   logic [31:0] mem_RD;

   logic [31:0] mem [0:31];
   logic [31:0] ref_mem [0:31];
   logic        preload;

   int checks;
   int failures;

   load_store_unit #(.MEM_WORDS(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .mem_A      (mem_A),
      .mem_WD     (mem_WD),
      .mem_WE     (mem_WE),
      .mem_RD     (mem_RD)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered memory: read returns the pre-write contents one edge later.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 32; i++) mem[i] <= 32'(i);
         mem_RD <= 32'd0;
      end else begin
         mem_RD <= (mem_A < 32'd32) ? mem[mem_A[4:0]] : 32'd0;
         if (mem_WE && (mem_A < 32'd32)) mem[mem_A[4:0]] <= mem_WD;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference behaviour from the architectural rules, using plain arithmetic.
   function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, output logic err,
                                 output logic [31:0] rdata, output logic [31:0] new_word,
                                 output int lat);
      int unsigned size;
      int unsigned idx;
      int unsigned lane;
      logic        illegal;
      logic [31:0] v;
      logic [63:0] mask;
      size = 1 << (f3 % 4);
      idx  = addr / 4;
      lane = addr % 4;
      illegal = we ? (f3 >= 3) : (f3 == 3 || f3 >= 6);
      err = illegal || ((addr % size) != 0) || (idx >= 32);
      rdata = 32'd0;
      new_word = 32'd0;
      if (err) begin
         lat = 1;
      end else if (!we) begin
         lat = 2;
         v = ref_mem[idx] >> (8 * lane);
         if (size == 1) begin
            v = v % 256;
            if (f3 == 0 && v >= 128) v = v - 32'd256;
         end else if (size == 2) begin
            v = v % 65536;
            if (f3 == 1 && v >= 32768) v = v - 32'd65536;
         end
         rdata = v;
      end else if (size == 4) begin
         lat = 2;
         new_word = wdata;
      end else begin
         lat = 3;
         mask = ((64'd1 << (8 * size)) - 64'd1) << (8 * lane);
         new_word = (ref_mem[idx] & ~mask[31:0]) | ((wdata << (8 * lane)) & mask[31:0]);
      end
   endfunction

   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] got);
      logic        e_err;
      logic [31:0] e_rdata;
      logic [31:0] e_word;
      int          e_lat;
      int          we_pulses;
      logic        seen;
      logic [31:0] wd_seen;
      model(we, f3, addr, wdata, e_err, e_rdata, e_word, e_lat);
      check("ready_before_req", 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      we_pulses = 0;
      seen      = 1'b0;
      got       = 32'd0;
      wd_seen   = 32'd0;
      for (int k = 1; k <= 6 && !seen; k++) begin
         @(negedge clk);
         if (mem_WE) begin
            we_pulses++;
            wd_seen = mem_WD;
            check("we_addr", mem_A, addr >> 2);
         end
         if (k == 1) check("access_addr", mem_A, e_err ? 32'd0 : (addr >> 2));
         if (rsp_valid) begin
            seen = 1'b1;
            got  = rsp_rdata;
            check("latency", 32'(k), 32'(e_lat));
            check("rdata", rsp_rdata, e_rdata);
            check("err", 32'(rsp_err), 32'(e_err));
            check("resp_mem_a", mem_A, 32'd0);
            check("resp_mem_wd", mem_WD, 32'd0);
         end else begin
            check("quiet_rdata", rsp_rdata, 32'd0);
            check("quiet_err", 32'(rsp_err), 32'd0);
         end
      end
      check("rsp_seen", 32'(seen), 32'd1);
      check("we_pulses", 32'(we_pulses), (we && !e_err) ? 32'd1 : 32'd0);
      if (we && !e_err) begin
         check("write_word", wd_seen, e_word);
         ref_mem[addr >> 2] = e_word;
      end
      @(negedge clk);
   endtask

   logic [31:0] got;
   logic [31:0] q_rdata[$];
   logic        q_err[$];

   initial begin
      int acc;
      int nrsp;
      int we_cnt;
      logic        e_err;
      logic [31:0] e_rdata;
      logic [31:0] e_word;
      int          e_lat;
      logic [2:0]  f3_tab [0:9];
      logic [31:0] e_r;
      logic        e_e;

      checks = 0;
      failures = 0;
      rst = 1'b1;
      preload = 1'b1;
      req_valid = 1'b0;
      req_we = 1'b0;
      req_funct3 = 3'd0;
      req_addr = 32'd0;
      req_wdata = 32'd0;
      for (int i = 0; i < 32; i++) ref_mem[i] = 32'(i);
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rdata", rsp_rdata, 32'd0);
      check("rst_err", 32'(rsp_err), 32'd0);
      check("rst_mem_a", mem_A, 32'd0);
      check("rst_mem_wd", mem_WD, 32'd0);
      check("rst_mem_we", 32'(mem_WE), 32'd0);
      preload = 1'b0;
      rst = 1'b0;
      @(negedge clk);

      do_req(1'b0, 3'd2, 32'h14, 32'd0, got);
      check("lw_0x14", got, 32'h5);
      do_req(1'b1, 3'd2, 32'h8, 32'h800080F0, got);
      do_req(1'b0, 3'd0, 32'h8, 32'd0, got);
      check("lb_0x8", got, 32'hFFFFFFF0);
      do_req(1'b0, 3'd4, 32'h9, 32'd0, got);
      check("lbu_0x9", got, 32'h00000080);
      do_req(1'b0, 3'd1, 32'hA, 32'd0, got);
      check("lh_0xa", got, 32'hFFFF8000);
      do_req(1'b0, 3'd5, 32'hA, 32'd0, got);
      check("lhu_0xa", got, 32'h00008000);
      do_req(1'b1, 3'd0, 32'hD, 32'h123456AB, got);
      do_req(1'b0, 3'd2, 32'hC, 32'd0, got);
      check("lw_after_sb", got, 32'h0000AB03);
      do_req(1'b1, 3'd1, 32'hE, 32'h0000BEEF, got);
      do_req(1'b0, 3'd2, 32'hC, 32'd0, got);
      check("lw_after_sh", got, 32'hBEEFAB03);

      do_req(1'b0, 3'd2, 32'h6, 32'd0, got);
      do_req(1'b1, 3'd1, 32'h3, 32'hFFFF, got);
      do_req(1'b0, 3'd3, 32'h0, 32'd0, got);
      do_req(1'b1, 3'd2, 32'h80, 32'hDEADBEEF, got);
      check("mem0_unchanged", mem[0], 32'd0);

      // Reset in the middle of an SB read-modify-write.
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'd0;
      req_addr   = 32'h10;
      req_wdata  = 32'h55;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("merge_we", 32'(mem_WE), 32'd1);
      rst = 1'b1;
      #1;
      check("rst_mid_we", 32'(mem_WE), 32'd0);
      check("rst_mid_ready", 32'(req_ready), 32'd1);
      check("rst_mid_rsp", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      check("rst_hold_rsp", 32'(rsp_valid), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_rsp", 32'(rsp_valid), 32'd0);
      check("mem4_kept", mem[4], 32'd4);
      do_req(1'b0, 3'd2, 32'h10, 32'd0, got);
      check("lw_after_rst", got, 32'h4);

      // req_valid held high with alternating SW/LW.
      acc = 0;
      nrsp = 0;
      we_cnt = 0;
      for (int c = 0; c < 60; c++) begin
         if (req_ready) begin
            if (acc < 8) begin
               req_valid  = 1'b1;
               req_we     = (acc % 2) == 0;
               req_funct3 = 3'd2;
               req_addr   = 32'h40 + 32'(4 * (acc / 2));
               req_wdata  = $urandom;
               model(req_we, req_funct3, req_addr, req_wdata, e_err, e_rdata, e_word, e_lat);
               if (req_we) ref_mem[req_addr >> 2] = e_word;
               q_rdata.push_back(e_rdata);
               q_err.push_back(e_err);
               acc++;
            end else begin
               req_valid = 1'b0;
            end
         end
         @(posedge clk);
         @(negedge clk);
         if (mem_WE) we_cnt++;
         check("held_no_overlap", 32'(rsp_valid && req_ready), 32'd0);
         if (rsp_valid) begin
            nrsp++;
            if (q_rdata.size() == 0) begin
               check("held_extra_rsp", 32'(q_rdata.size()), 32'd1);
            end else begin
               e_r = q_rdata.pop_front();
               e_e = q_err.pop_front();
               check("held_rdata", rsp_rdata, e_r);
               check("held_err", 32'(rsp_err), 32'(e_e));
            end
         end
      end
      req_valid = 1'b0;
      check("held_accepts", 32'(acc), 32'd8);
      check("held_responses", 32'(nrsp), 32'd8);
      check("held_we_count", 32'(we_cnt), 32'd4);

      // Random traffic, biased toward legal width codes.
      f3_tab[0] = 3'd0; f3_tab[1] = 3'd1; f3_tab[2] = 3'd2; f3_tab[3] = 3'd4; f3_tab[4] = 3'd5;
      f3_tab[5] = 3'd0; f3_tab[6] = 3'd1; f3_tab[7] = 3'd2; f3_tab[8] = 3'd3; f3_tab[9] = 3'd6;
      for (int n = 0; n < 80; n++) begin
         logic [31:0] a;
         a = 32'($urandom_range(0, 33)) * 32'd4 + 32'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 0) a = a & ~32'd1;
         do_req(1'($urandom_range(0, 1)), f3_tab[$urandom_range(0, 9)], a, $urandom, got);
      end

      for (int i = 0; i < 32; i++) check("final_mem", mem[i], ref_mem[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
